// File: rtl/imm_gen.sv
// RV32I immediate generator: decodes the opcode format and registers imm/fmt.
// Optional IMMGEN_ZICSR_EN maps CSR*I instructions to the zero-extended Z format.
module imm_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic [2:0]  fmt
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]  op;
    logic        is_sys;
    logic        is_i;
    logic        is_s;
    logic        is_b;
    logic        is_u;
    logic        is_j;
    logic        is_z;
    logic [31:0] imm_d;
    fmt_t        fmt_d;
    logic [31:0] imm_q;
    fmt_t        fmt_q;

    assign op     = instr[6:0];
    assign is_sys = (op == OP_SYSTEM);

`ifdef IMMGEN_ZICSR_EN
    assign is_z = is_sys && instr[14];
`else
    assign is_z = 1'b0;
`endif

    // SYSTEM is I-type unless it was claimed as a CSR immediate form
    assign is_i = (op == OP_LOAD) || (op == OP_IMM) ||
                  (op == OP_JALR) || (op == OP_MISC) ||
                  (is_sys && !is_z);
    assign is_s = (op == OP_STORE);
    assign is_b = (op == OP_BRANCH);
    assign is_u = (op == OP_LUI) || (op == OP_AUIPC);
    assign is_j = (op == OP_JAL);

    always_comb begin
        imm_d = 32'h0;
        fmt_d = FMT_NONE;
        unique case (1'b1)
            is_i: begin
                imm_d = {{21{instr[31]}}, instr[30:20]};
                fmt_d = FMT_I;
            end
            is_s: begin
                imm_d = {{21{instr[31]}}, instr[30:25], instr[11:7]};
                fmt_d = FMT_S;
            end
            is_b: begin
                imm_d = {{20{instr[31]}}, instr[7], instr[30:25],
                         instr[11:8], 1'b0};
                fmt_d = FMT_B;
            end
            is_u: begin
                imm_d = {instr[31:12], 12'h000};
                fmt_d = FMT_U;
            end
            is_j: begin
                imm_d = {{12{instr[31]}}, instr[19:12], instr[20],
                         instr[30:21], 1'b0};
                fmt_d = FMT_J;
            end
            is_z: begin
                imm_d = {27'h0, instr[19:15]};
                fmt_d = FMT_Z;
            end
            default: begin
                imm_d = 32'h0;
                fmt_d = FMT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q <= 32'h0;
            fmt_q <= FMT_NONE;
        end else if (en) begin
            imm_q <= imm_d;
            fmt_q <= fmt_d;
        end
    end

    assign imm = imm_q;
    assign fmt = fmt_q;

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: vector table through a scoreboard queue,
// plus hand-written hold and asynchronous-reset sequences.
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;

    imm_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .instr (instr),
        .imm   (imm),
        .fmt   (fmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    int   n_vec;
    int   n_bad;
    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name,
                         input logic [31:0] eimm,
                         input logic [2:0]  efmt);
        n_vec++;
        if (imm !== eimm || fmt !== efmt) begin
            n_bad++;
            $display("FAIL %s: got imm=%08h fmt=%0d, want imm=%08h fmt=%0d",
                     name, imm, fmt, eimm, efmt);
        end
    endtask

    task automatic add(input string n, input logic [31:0] i,
                       input logic [31:0] m, input logic [2:0] f);
        vec_t v;
        v.name  = n;
        v.instr = i;
        v.imm   = m;
        v.fmt   = f;
        vecs.push_back(v);
    endtask

    task automatic drive(input string n, input logic [31:0] i,
                         input logic [31:0] m, input logic [2:0] f);
        exp_t e;
        @(negedge clk);
        instr = i;
        en    = 1'b1;
        e.name = n;
        e.imm  = m;
        e.fmt  = f;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: empty queue at sample");
        end else begin
            e = sb.pop_front();
            check(e.name, e.imm, e.fmt);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        instr = 32'hFFF00093;
        #1;
        check("reset_state", 32'h0, 3'd0);
        @(posedge clk);
        #1;
        check("reset_hold_en", 32'h0, 3'd0);

        add("addi_m1",   32'hFFF00093, 32'hFFFFFFFF, 3'd1);
        add("sw_m4",     32'hFE20AE23, 32'hFFFFFFFC, 3'd2);
        add("lui",       32'h123452B7, 32'h12345000, 3'd4);
        add("jal_m4",    32'hFFDFF06F, 32'hFFFFFFFC, 3'd5);
        add("beq_p8",    32'h00000463, 32'h00000008, 3'd3);
        add("add_none",  32'h003100B3, 32'h00000000, 3'd0);
        add("srai",      32'h40315093, 32'h00000403, 3'd1);
        add("lw_m2048",  32'h80012083, 32'hFFFFF800, 3'd1);
        add("auipc",     32'hFFFFF097, 32'hFFFFF000, 3'd4);
        add("jalr_0",    32'h000080E7, 32'h00000000, 3'd1);
        add("fence",     32'h0FF0000F, 32'h000000FF, 3'd1);
        add("compr",     32'h00004501, 32'h00000000, 3'd0);
        add("b_minneg",  32'h80000063, 32'hFFFFF000, 3'd3);
        add("j_minneg",  32'h8000006F, 32'hFFF00000, 3'd5);
        add("s_p31",     32'h00000FA3, 32'h0000001F, 3'd2);
        add("csrrs",     32'h30002073, 32'h00000300, 3'd1);
`ifdef IMMGEN_ZICSR_EN
        add("csrrwi",    32'h3002D073, 32'h00000005, 3'd6);
        add("csrrci",    32'hC00FF073, 32'h0000001F, 3'd6);
`else
        add("csrrwi",    32'h3002D073, 32'h00000300, 3'd1);
        add("csrrci",    32'hC00FF073, 32'hFFFFFC00, 3'd1);
`endif

        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back: en stays high across every vector
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].name, vecs[k].instr, vecs[k].imm, vecs[k].fmt);
            sample();
        end

        drive("hold_load", 32'hFFF00093, 32'hFFFFFFFF, 3'd1);
        sample();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            en    = 1'b0;
            instr = 32'h123452B7;
            @(posedge clk);
            #1;
            check($sformatf("hold_c%0d", k), 32'hFFFFFFFF, 3'd1);
        end

        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'h0, 3'd0);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("reset_en_hi", 32'h0, 3'd0);
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("no_replay", 32'h0, 3'd0);

        drive("post_lui", 32'h123452B7, 32'h12345000, 3'd4);
        sample();
        drive("post_add", 32'h003100B3, 32'h00000000, 3'd0);
        sample();

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
